// File: rtl/axi4_stream_pkt_trunc_if.sv
// ----------------------------------------------------------------------------
// axi4_stream_if
// AXI4-Stream bundle used on both sides of the packet truncation stage.
//   tvalid/tready : handshake
//   tdata         : DATA_WIDTH payload
//   tstrb/tkeep   : DATA_WIDTH/8 byte qualifiers
//   tlast         : end of packet
//   tuser/tid/tdest : sideband, widths set by parameters
// Modports: master drives everything except tready; slave drives tready only.
// ----------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );
endinterface

// File: rtl/axi4_stream_pkt_trunc.sv
// ----------------------------------------------------------------------------
// axi4_stream_pkt_trunc
// Single registered AXI4-Stream stage that caps packets at MAX_PKT_WORDS beats.
// A packet that would exceed the cap has its MAX_PKT_WORDS-th beat forwarded
// with tlast forced high; the rest of that packet is swallowed (tready held
// high, nothing forwarded) until the source's own tlast beat.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   slave_if     : input stream (tready driven here)
//   master_if    : output stream, all fields from flops
//   trunc_o      : one-cycle pulse the cycle after a packet is cut
//   trunc_pkts_o : saturating count of cut packets
// ----------------------------------------------------------------------------
module axi4_stream_pkt_trunc #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEST_WIDTH    = 1,
    parameter int USER_WIDTH    = 1,
    parameter int ID_WIDTH      = 1,
    parameter int MAX_PKT_WORDS = 256,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi4_stream_if.slave         slave_if,
    axi4_stream_if.master        master_if,
    output logic                 trunc_o,
    output logic [CNT_WIDTH-1:0] trunc_pkts_o
);
    localparam int BCW = $clog2(MAX_PKT_WORDS + 1);
    localparam int KW  = DATA_WIDTH / 8;
    localparam logic [BCW-1:0]       LAST_IDX = BCW'(MAX_PKT_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BCW-1:0]        r_beat_cnt;
    logic [BCW-1:0]        w_beat_cnt_nxt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [KW-1:0]         r_strb;
    logic [KW-1:0]         r_keep;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DEST_WIDTH-1:0] r_dest;
    logic                  r_trunc;
    logic [CNT_WIDTH-1:0]  r_trunc_cnt;
    logic                  w_ready;
    logic                  w_load;
    logic                  w_cut;
    logic                  w_deliver;

    assign w_deliver = r_valid & master_if.tready;

    // Next-state, beat counter, ready and load/cut decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_ready        = 1'b0;
        w_load         = 1'b0;
        w_cut          = 1'b0;
        case (r_state)
            ST_PASS: begin
                // Only path from master to slave side: tready passthrough.
                w_ready = ~r_valid | master_if.tready;
                if (slave_if.tvalid && w_ready) begin
                    w_load = 1'b1;
                    if (slave_if.tlast) begin
                        w_beat_cnt_nxt = {BCW{1'b0}};
                    end else if (r_beat_cnt == LAST_IDX) begin
                        // Last allowed beat without tlast: cut the packet here.
                        w_cut          = 1'b1;
                        w_beat_cnt_nxt = {BCW{1'b0}};
                        w_state_nxt    = ST_DROP;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + BCW'(1'b1);
                    end
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt;
                end
            end
            ST_DROP: begin
                // Swallow the tail regardless of downstream backpressure.
                w_ready = 1'b1;
                if (slave_if.tvalid && slave_if.tlast) begin
                    w_state_nxt = ST_PASS;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt    = ST_PASS;
                w_beat_cnt_nxt = {BCW{1'b0}};
            end
        endcase
    end

    // Control flops: state, beat counter, output valid, truncation status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_PASS;
            r_beat_cnt  <= {BCW{1'b0}};
            r_valid     <= 1'b0;
            r_trunc     <= 1'b0;
            r_trunc_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            if (w_load) begin
                r_valid <= 1'b1;
            end else if (w_deliver) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
            r_trunc <= w_cut;
            if (w_cut && (r_trunc_cnt != CNT_MAX)) begin
                r_trunc_cnt <= r_trunc_cnt + CNT_WIDTH'(1'b1);
            end else begin
                r_trunc_cnt <= r_trunc_cnt;
            end
        end
    end

    // Payload register; no reset needed since r_valid qualifies it.
    always_ff @(posedge clk_i) begin
        if (w_load) begin
            r_data <= slave_if.tdata;
            r_strb <= slave_if.tstrb;
            r_keep <= slave_if.tkeep;
            r_last <= slave_if.tlast | w_cut;
            r_user <= slave_if.tuser;
            r_id   <= slave_if.tid;
            r_dest <= slave_if.tdest;
        end else begin
            r_data <= r_data;
            r_strb <= r_strb;
            r_keep <= r_keep;
            r_last <= r_last;
            r_user <= r_user;
            r_id   <= r_id;
            r_dest <= r_dest;
        end
    end

    // Input is never accepted while reset is applied.
    assign slave_if.tready  = w_ready & ~rst_i;

    assign master_if.tvalid = r_valid;
    assign master_if.tdata  = r_data;
    assign master_if.tstrb  = r_strb;
    assign master_if.tkeep  = r_keep;
    assign master_if.tlast  = r_last;
    assign master_if.tuser  = r_user;
    assign master_if.tid    = r_id;
    assign master_if.tdest  = r_dest;
    assign trunc_o          = r_trunc;
    assign trunc_pkts_o     = r_trunc_cnt;
endmodule

// File: tb/tb_axi4_stream_pkt_trunc.sv
// ----------------------------------------------------------------------------
// tb_axi4_stream_pkt_trunc
// Three instances share one input stream:
//   A: MAX_PKT_WORDS=4, CNT_WIDTH=16 (main target, random backpressure phase)
//   B: MAX_PKT_WORDS=1, CNT_WIDTH=16
//   C: MAX_PKT_WORDS=4, CNT_WIDTH=2  (counter saturation)
// Expected beats are queued per instance before each packet is sent and
// popped as the instance delivers them.
// ----------------------------------------------------------------------------
module tb_axi4_stream_pkt_trunc;
    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_bc;
    logic        s_valid;
    logic        s_last;
    logic [31:0] s_data;
    logic        m_ready_a;
    logic        rand_mode;

    logic        trunc_a, trunc_b, trunc_c;
    logic [15:0] pkts_a, pkts_b;
    logic [1:0]  pkts_c;

    int n_vec = 0;
    int n_err = 0;
    int pulses_a = 0, pulses_b = 0, pulses_c = 0;
    int stall_total = 0;
    int long_cnt = 0;

    logic [43:0] exp_a[$];
    logic [43:0] exp_b[$];
    logic [43:0] exp_c[$];

    always #5 clk = ~clk;

    axi4_stream_if a_s(); axi4_stream_if a_m();
    axi4_stream_if b_s(); axi4_stream_if b_m();
    axi4_stream_if c_s(); axi4_stream_if c_m();

    assign a_s.tvalid = s_valid; assign a_s.tdata = s_data; assign a_s.tlast = s_last;
    assign a_s.tstrb = s_data[3:0]; assign a_s.tkeep = s_data[7:4];
    assign a_s.tuser = s_data[8]; assign a_s.tid = s_data[9]; assign a_s.tdest = s_data[10];
    assign b_s.tvalid = s_valid; assign b_s.tdata = s_data; assign b_s.tlast = s_last;
    assign b_s.tstrb = s_data[3:0]; assign b_s.tkeep = s_data[7:4];
    assign b_s.tuser = s_data[8]; assign b_s.tid = s_data[9]; assign b_s.tdest = s_data[10];
    assign c_s.tvalid = s_valid; assign c_s.tdata = s_data; assign c_s.tlast = s_last;
    assign c_s.tstrb = s_data[3:0]; assign c_s.tkeep = s_data[7:4];
    assign c_s.tuser = s_data[8]; assign c_s.tid = s_data[9]; assign c_s.tdest = s_data[10];
    assign a_m.tready = m_ready_a;
    assign b_m.tready = 1'b1;
    assign c_m.tready = 1'b1;

    axi4_stream_pkt_trunc #(.MAX_PKT_WORDS(4), .CNT_WIDTH(16)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .slave_if(a_s), .master_if(a_m),
        .trunc_o(trunc_a), .trunc_pkts_o(pkts_a));
    axi4_stream_pkt_trunc #(.MAX_PKT_WORDS(1), .CNT_WIDTH(16)) u_dut_b (
        .clk_i(clk), .rst_i(rst_bc), .slave_if(b_s), .master_if(b_m),
        .trunc_o(trunc_b), .trunc_pkts_o(pkts_b));
    axi4_stream_pkt_trunc #(.MAX_PKT_WORDS(4), .CNT_WIDTH(2)) u_dut_c (
        .clk_i(clk), .rst_i(rst_bc), .slave_if(c_s), .master_if(c_m),
        .trunc_o(trunc_c), .trunc_pkts_o(pkts_c));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] beat_word(input logic [31:0] d, input logic l);
        return {d[7:4], d[3:0], d[10], d[9], d[8], l, d};
    endfunction

    function automatic logic [43:0] out_word_a();
        return {a_m.tkeep, a_m.tstrb, a_m.tdest, a_m.tid, a_m.tuser, a_m.tlast, a_m.tdata};
    endfunction

    task automatic exp_ac(input logic [31:0] d, input logic l);
        exp_a.push_back(beat_word(d, l));
        exp_c.push_back(beat_word(d, l));
    endtask

    task automatic exp_b1(input logic [31:0] d, input logic l);
        exp_b.push_back(beat_word(d, l));
    endtask

    // Present one beat from posedge+1 and hold it until instance A accepts it.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!a_s.tready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!a_s.tready) check_eq("accept_timeout", 64'(a_s.tready), 64'd1);
        stall_total += waited;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] base, input int len);
        for (int i = 1; i <= len; i++) send_beat(base + 32'(i), (i == len));
    endtask

    // Wait (bounded) for every expected beat to come out, then realign to posedge+1.
    task automatic settle();
        for (int i = 0; i < 500 && (exp_a.size() + exp_b.size() + exp_c.size()) != 0; i++)
            @(negedge clk);
        check_eq("a_drained", 64'(exp_a.size()), 64'd0);
        check_eq("b_drained", 64'(exp_b.size()), 64'd0);
        check_eq("c_drained", 64'(exp_c.size()), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    logic        stall_prev = 1'b0;
    logic [44:0] stall_word;

    // Instance A: scoreboard pop, stall stability, trunc pulse count.
    always @(negedge clk) begin
        if (!rst_a && a_m.tvalid && a_m.tready) begin
            if (exp_a.size() == 0) check_eq("a_unexpected_beat", 64'(out_word_a()), {64{1'b1}});
            else check_eq("a_beat", 64'(out_word_a()), 64'(exp_a.pop_front()));
        end
        if (!rst_a && stall_prev) check_eq("a_stall_hold", 64'({a_m.tvalid, out_word_a()}), 64'(stall_word));
        stall_prev = !rst_a && a_m.tvalid && !a_m.tready;
        stall_word = {1'b1, out_word_a()};
        if (!rst_a && trunc_a) pulses_a++;
    end

    // Instances B and C: scoreboard pop and trunc pulse count.
    always @(negedge clk) begin
        if (!rst_bc && b_m.tvalid) begin
            if (exp_b.size() == 0) check_eq("b_unexpected_beat", 64'(b_m.tdata), {64{1'b1}});
            else check_eq("b_beat", 64'({b_m.tkeep, b_m.tstrb, b_m.tdest, b_m.tid, b_m.tuser,
                                         b_m.tlast, b_m.tdata}), 64'(exp_b.pop_front()));
        end
        if (!rst_bc && c_m.tvalid) begin
            if (exp_c.size() == 0) check_eq("c_unexpected_beat", 64'(c_m.tdata), {64{1'b1}});
            else check_eq("c_beat", 64'({c_m.tkeep, c_m.tstrb, c_m.tdest, c_m.tid, c_m.tuser,
                                         c_m.tlast, c_m.tdata}), 64'(exp_c.pop_front()));
        end
        if (!rst_bc && trunc_b) pulses_b++;
        if (!rst_bc && trunc_c) pulses_c++;
    end

    // Backpressure on A: always ready except during the random phase.
    always @(posedge clk) begin
        #1;
        m_ready_a = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        int len, k;
        rst_a = 1'b1; rst_bc = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 32'd0;
        m_ready_a = 1'b1; rand_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tvalid", 64'(a_m.tvalid), 64'd0);
        check_eq("rst_tready", 64'(a_s.tready), 64'd0);
        check_eq("rst_trunc", 64'(trunc_a), 64'd0);
        check_eq("rst_pkts_a", 64'(pkts_a), 64'd0);
        check_eq("rst_pkts_c", 64'(pkts_c), 64'd0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_bc = 1'b0;

        // Single-beat packet: one-cycle latency, passes on all instances.
        exp_ac(32'h0000_0A51, 1'b1); exp_b1(32'h0000_0A51, 1'b1);
        s_valid = 1'b1; s_data = 32'h0000_0A51; s_last = 1'b1;
        @(negedge clk);
        check_eq("p0_ready", 64'(a_s.tready), 64'd1);
        check_eq("p0_no_early_valid", 64'(a_m.tvalid), 64'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check_eq("p0_lat_valid", 64'(a_m.tvalid), 64'd1);
        check_eq("p0_lat_word", 64'(out_word_a()), 64'(beat_word(32'h0000_0A51, 1'b1)));
        @(negedge clk);
        check_eq("p0_emptied", 64'(a_m.tvalid), 64'd0);
        settle();

        // 3-beat packet under the cap.
        exp_ac(32'h0101, 1'b0); exp_ac(32'h0102, 1'b0); exp_ac(32'h0103, 1'b1);
        exp_b1(32'h0101, 1'b1);
        send_pkt(32'h0100, 3);
        settle();
        check_eq("p1_pkts_a", 64'(pkts_a), 64'd0);
        check_eq("p1_pkts_b", 64'(pkts_b), 64'd1);

        // 4-beat packet exactly at the cap: no truncation.
        exp_ac(32'h0201, 1'b0); exp_ac(32'h0202, 1'b0); exp_ac(32'h0203, 1'b0);
        exp_ac(32'h0204, 1'b1); exp_b1(32'h0201, 1'b1);
        send_pkt(32'h0200, 4);
        settle();
        check_eq("p2_pulses_a", 64'(pulses_a), 64'd0);
        check_eq("p2_pkts_a", 64'(pkts_a), 64'd0);
        check_eq("p2_pulses_b", 64'(pulses_b), 64'd2);

        // 7-beat packet cut after beat 4, then a 2-beat packet intact.
        exp_ac(32'h0301, 1'b0); exp_ac(32'h0302, 1'b0); exp_ac(32'h0303, 1'b0);
        exp_ac(32'h0304, 1'b1); exp_b1(32'h0301, 1'b1);
        exp_ac(32'h0401, 1'b0); exp_ac(32'h0402, 1'b1); exp_b1(32'h0401, 1'b1);
        send_pkt(32'h0300, 7);
        send_pkt(32'h0400, 2);
        settle();
        check_eq("p3_pkts_a", 64'(pkts_a), 64'd1);
        check_eq("p3_pulses_a", 64'(pulses_a), 64'd1);
        check_eq("p3_pkts_c", 64'(pkts_c), 64'd1);
        check_eq("p3_no_stall", 64'(stall_total), 64'd0);

        // Four more over-length packets: C saturates at 3 but keeps pulsing.
        for (int p = 5; p <= 8; p++) begin
            base = 32'(p) << 8;
            exp_ac(base + 32'd1, 1'b0); exp_ac(base + 32'd2, 1'b0);
            exp_ac(base + 32'd3, 1'b0); exp_ac(base + 32'd4, 1'b1);
            exp_b1(base + 32'd1, 1'b1);
            send_pkt(base, 5);
        end
        settle();
        check_eq("sat_pkts_a", 64'(pkts_a), 64'd5);
        check_eq("sat_pulses_a", 64'(pulses_a), 64'd5);
        check_eq("sat_pkts_c", 64'(pkts_c), 64'd3);
        check_eq("sat_pulses_c", 64'(pulses_c), 64'd5);
        check_eq("sat_pkts_b", 64'(pkts_b), 64'd8);
        check_eq("sat_pulses_b", 64'(pulses_b), 64'd8);

        // Reset while dropping beat 6 of a 9-beat packet.
        exp_ac(32'h0901, 1'b0); exp_ac(32'h0902, 1'b0); exp_ac(32'h0903, 1'b0);
        exp_ac(32'h0904, 1'b1); exp_b1(32'h0901, 1'b1);
        for (int i = 1; i <= 5; i++) send_beat(32'h0900 + 32'(i), 1'b0);
        s_valid = 1'b1; s_data = 32'h0906; s_last = 1'b0;
        rst_a = 1'b1; rst_bc = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_tready", 64'(a_s.tready), 64'd0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_bc = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_tvalid", 64'(a_m.tvalid), 64'd0);
        check_eq("mid_rst_pkts_a", 64'(pkts_a), 64'd0);
        @(posedge clk); #1;
        exp_ac(32'h0907, 1'b0); exp_ac(32'h0908, 1'b0); exp_ac(32'h0909, 1'b1);
        exp_b1(32'h0907, 1'b1);
        send_beat(32'h0907, 1'b0); send_beat(32'h0908, 1'b0); send_beat(32'h0909, 1'b1);
        settle();
        check_eq("post_rst_pkts_a", 64'(pkts_a), 64'd0);
        check_eq("post_rst_pkts_c", 64'(pkts_c), 64'd0);
        check_eq("post_rst_pkts_b", 64'(pkts_b), 64'd1);

        // Random traffic on A only; B and C held in reset.
        rst_a = 1'b1; rst_bc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0; pulses_a = 0; rand_mode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 10);
            k = (len > 4) ? 4 : len;
            if (len > 4) long_cnt++;
            for (int i = 1; i <= k; i++) exp_a.push_back(beat_word({16'(p), 16'(i)}, (i == k)));
            for (int i = 1; i <= len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send_beat({16'(p), 16'(i)}, (i == len));
            end
        end
        settle();
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rand_pkts_a", 64'(pkts_a), 64'(long_cnt));
        check_eq("rand_pulses_a", 64'(pulses_a), 64'(long_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
